fadd_arbiter: RTL

- Shares one pipelined single-precision fadd unit among NREQ requesters (FPU issue ports).
- Each cycle it picks at most one request round-robin, drives the request's operands to the fadd unit, and tracks it through the fixed-latency pipeline with a shift register of valid/id/tag.
- Returns the registered result to the originating requester.
- Sits between the FPU issue logic and the fadd instance; the fadd is instantiated outside this block.

---
 rtl/fadd_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin front end that shares one fixed-latency fadd
// pipeline among NREQ issue ports and routes each result back to the port
// that issued it. A valid/id/tag shift register tracks in-flight requests.
// Optional build macro FADD_ARB_PERF_EN adds saturating issue/conflict counters.
module fadd_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [31:0]          fu_x1,
  output logic [31:0]          fu_x2,
  input  logic [31:0]          fu_y,
  input  logic                 fu_ovf,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_y,
  output logic                 rsp_ovf,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 busy
`ifdef FADD_ARB_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_conflict_cnt
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Index arithmetic modulo NREQ; NREQ need not be a power of two.
  function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NREQ) sum = sum - NREQ;
    return PTRW'(sum);
  endfunction

  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] winner;
  logic            found;
  logic            issue;
  logic [TAGW-1:0] win_tag;

  logic [LAT-1:0]  pipe_v;
  logic [PTRW-1:0] pipe_id  [LAT];
  logic [TAGW-1:0] pipe_tag [LAT];
  logic [NREQ-1:0] rsp_sel;

  // Round-robin scan starting at ptr: first pending requester wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred. Combinational logic
    // uses blocking '=', clocked state uses non-blocking '<='.
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[wrap_add(ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_add(ptr, k);
      end
    end
  end

  // Grants are suppressed while reset is held, so nothing reaches the fadd.
  assign issue   = found & ~rst;
  assign win_tag = req_tag[TAGW*int'(winner) +: TAGW];

  // One-hot grant back to the winner and operand mux toward the fadd.
  always_comb begin
    req_ready = '0;
    fu_x1     = '0;
    fu_x2     = '0;
    if (issue) begin
      req_ready[winner] = 1'b1;
      fu_x1             = req_x1[32*int'(winner) +: 32];
      fu_x2             = req_x2[32*int'(winner) +: 32];
    end
  end

  // Pointer advances past the winner on a grant and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= wrap_add(winner, 1);
    end
  end

  // Valid bits of the tracking pipeline; the fadd never stalls, so shift every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= issue;
      for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Id/tag payload of the tracking pipeline, qualified by pipe_v.
  always_ff @(posedge clk) begin
    // NOTE: payload registers have no reset; they are only observed when the
    // matching valid bit is set, and that bit is reset.
    pipe_id[0]  <= winner;
    pipe_tag[0] <= win_tag;
    for (int i = 1; i < LAT; i++) begin
      pipe_id[i]  <= pipe_id[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  // Decode the id of the oldest entry into the one-hot response strobe.
  always_comb begin
    rsp_sel                 = '0;
    rsp_sel[pipe_id[LAT-1]] = 1'b1;
  end

  // Capture the fadd result when the oldest entry retires; data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
      rsp_ovf   <= 1'b0;
      rsp_tag   <= '0;
    end else if (pipe_v[LAT-1]) begin
      rsp_valid <= rsp_sel;
      rsp_y     <= fu_y;
      rsp_ovf   <= fu_ovf;
      rsp_tag   <= pipe_tag[LAT-1];
    end else begin
      rsp_valid <= '0;
    end
  end

  assign busy = (|pipe_v) | (|rsp_valid);

`ifdef FADD_ARB_PERF_EN
  logic multi_req;

  // Two or more pending bits: clearing the lowest set bit leaves something.
  assign multi_req = |(req_valid & (req_valid - NREQ'(1)));

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (issue && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if (multi_req && (perf_conflict_cnt != 32'hFFFF_FFFF)) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
